// File: rtl/retire_stage_nw_pkg.sv
// Shared types for the N-wide retire stage: exception codes, per-ROB-slot
// completion record and the retire FSM state.
package retire_stage_nw_pkg;

  localparam int XLEN       = 32;
  localparam int ROB_SZ_DEF = 32;

  typedef enum logic [3:0] {
    NO_ERROR          = 4'h0,
    ILLEGAL_INST      = 4'h2,
    LOAD_ACCESS_FAULT = 4'h5,
    HALTED_ON_WFI     = 4'hF
  } EXCEPTION_CODE;

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic [4:0]        wr_idx;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN-1:0]   NPC;
    EXCEPTION_CODE     error;
  } RETIRE_ENTRY;

  typedef enum logic [0:0] {
    RET_RUN    = 1'b0,
    RET_HALTED = 1'b1
  } RETIRE_STATE;

endpackage

// File: rtl/retire_stage_nw_select.sv
// Lane eligibility: in-order prefix chain over the head slots; a faulting
// lane retires itself but blocks every younger lane.
module retire_select
  import retire_stage_nw_pkg::*;
#(
  parameter int RETIRE_W = 2,
  parameter int IDX_W    = 5,
  parameter int HA_W     = 2
) (
  input  logic [RETIRE_W-1:0] i_slot_valid,
  input  logic [RETIRE_W-1:0] i_slot_err,
  input  logic [IDX_W:0]      i_rob_count,
  input  RETIRE_STATE         i_state,
  output logic [RETIRE_W-1:0] o_ret_valid,
  output logic [HA_W-1:0]     o_head_advance
);

  logic            w_ok;
  logic [HA_W-1:0] w_cnt;

  always_comb begin
    w_ok        = (i_state == RET_RUN);
    w_cnt       = '0;
    o_ret_valid = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (w_ok && ((IDX_W+1)'(i) < i_rob_count) && i_slot_valid[i]) begin
        o_ret_valid[i] = 1'b1;
        w_cnt          = w_cnt + 1'b1;
        w_ok           = !i_slot_err[i];
      end else begin
        w_ok = 1'b0;
      end
    end
    o_head_advance = w_cnt;
  end

endmodule

// File: rtl/retire_stage_nw.sv
// N-wide in-order retire stage: ROB-indexed completion buffer, head-window
// retire selection and a sticky halt/error FSM.
module retire_stage_nw
  import retire_stage_nw_pkg::*;
#(
  parameter int ROB_SZ   = ROB_SZ_DEF,
  parameter int RETIRE_W = 2,
  parameter int CMPL_W   = 2,
  localparam int IDX_W   = $clog2(ROB_SZ),
  localparam int HA_W    = $clog2(RETIRE_W+1)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [CMPL_W-1:0]                cmpl_valid,
  input  logic [CMPL_W-1:0][IDX_W-1:0]     cmpl_rob_idx,
  input  logic [CMPL_W-1:0]                cmpl_wr_en,
  input  logic [CMPL_W-1:0][4:0]           cmpl_wr_idx,
  input  logic [CMPL_W-1:0][XLEN-1:0]      cmpl_wr_data,
  input  logic [CMPL_W-1:0][XLEN-1:0]      cmpl_NPC,
  input  EXCEPTION_CODE [CMPL_W-1:0]       cmpl_error,
  input  logic [IDX_W-1:0]                 rob_head,
  input  logic [IDX_W:0]                   rob_count,
  input  logic                             flush,
  output logic [HA_W-1:0]                  head_advance,
  output logic [RETIRE_W-1:0]              ret_valid,
  output logic [RETIRE_W-1:0]              ret_wr_en,
  output logic [RETIRE_W-1:0][4:0]         ret_wr_idx,
  output logic [RETIRE_W-1:0][XLEN-1:0]    ret_wr_data,
  output logic [RETIRE_W-1:0][XLEN-1:0]    ret_NPC,
  output logic [3:0]                       completed_insts,
  output EXCEPTION_CODE                    error_status,
  output logic                             halted
);

  RETIRE_ENTRY   r_buf [ROB_SZ];
  RETIRE_STATE   r_state;
  EXCEPTION_CODE r_err;

  logic [RETIRE_W-1:0][IDX_W-1:0] w_slot;
  RETIRE_ENTRY                    w_head [RETIRE_W];
  logic [RETIRE_W-1:0]            w_hv, w_he;
  logic                           w_halt_hit;
  EXCEPTION_CODE                  w_halt_code;

  // Lane payloads are gated so every output reads zero when nothing retires.
  for (genvar g = 0; g < RETIRE_W; g++) begin : g_lane
    assign w_slot[g]      = IDX_W'(rob_head + IDX_W'(g));
    assign w_head[g]      = r_buf[w_slot[g]];
    assign w_hv[g]        = w_head[g].valid;
    assign w_he[g]        = (w_head[g].error != NO_ERROR);
    assign ret_wr_en[g]   = ret_valid[g] & w_head[g].wr_en;
    assign ret_wr_idx[g]  = ret_valid[g] ? w_head[g].wr_idx  : '0;
    assign ret_wr_data[g] = ret_valid[g] ? w_head[g].wr_data : '0;
    assign ret_NPC[g]     = ret_valid[g] ? w_head[g].NPC     : '0;
  end

  retire_select #(
    .RETIRE_W (RETIRE_W),
    .IDX_W    (IDX_W),
    .HA_W     (HA_W)
  ) u_sel (
    .i_slot_valid   (w_hv),
    .i_slot_err     (w_he),
    .i_rob_count    (rob_count),
    .i_state        (r_state),
    .o_ret_valid    (ret_valid),
    .o_head_advance (head_advance)
  );

  // Only the youngest retiring lane can carry an error.
  always_comb begin
    w_halt_hit  = 1'b0;
    w_halt_code = NO_ERROR;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (ret_valid[i] && w_he[i]) begin
        w_halt_hit  = 1'b1;
        w_halt_code = w_head[i].error;
      end
    end
  end

  assign completed_insts = 4'(head_advance);
  assign error_status    = r_err;
  assign halted          = (r_state == RET_HALTED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < ROB_SZ; s++) r_buf[s] <= '0;
      r_state <= RET_RUN;
      r_err   <= NO_ERROR;
    end else begin
      if (flush) begin
        for (int s = 0; s < ROB_SZ; s++) r_buf[s].valid <= 1'b0;
      end else begin
        // Later assignments win: higher port over lower, retire-clear over capture.
        for (int p = 0; p < CMPL_W; p++) begin
          if (cmpl_valid[p])
            r_buf[cmpl_rob_idx[p]] <= '{valid: 1'b1, wr_en: cmpl_wr_en[p],
                                        wr_idx: cmpl_wr_idx[p], wr_data: cmpl_wr_data[p],
                                        NPC: cmpl_NPC[p], error: cmpl_error[p]};
        end
        for (int i = 0; i < RETIRE_W; i++) begin
          if (ret_valid[i]) r_buf[w_slot[i]].valid <= 1'b0;
        end
      end
      if (w_halt_hit) begin
        r_state <= RET_HALTED;
        r_err   <= w_halt_code;
      end
    end
  end

  always @(posedge clock) begin
    if (reset_n && !flush) begin
      for (int p = 0; p < CMPL_W; p++) begin
        for (int q = p + 1; q < CMPL_W; q++)
          assert (!(cmpl_valid[p] && cmpl_valid[q] && cmpl_rob_idx[p] == cmpl_rob_idx[q]));
        for (int i = 0; i < RETIRE_W; i++)
          assert (!(cmpl_valid[p] && ret_valid[i] && cmpl_rob_idx[p] == w_slot[i]));
      end
    end
  end

endmodule

// File: tb/tb_retire_stage_nw.sv
// Cycle-table bench for retire_stage_nw with a per-cycle expectation queue.
module tb_retire_stage_nw;
  import retire_stage_nw_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [1:0]           cmpl_valid;
  logic [1:0][4:0]      cmpl_rob_idx;
  logic [1:0]           cmpl_wr_en;
  logic [1:0][4:0]      cmpl_wr_idx;
  logic [1:0][31:0]     cmpl_wr_data;
  logic [1:0][31:0]     cmpl_NPC;
  EXCEPTION_CODE [1:0]  cmpl_error;
  logic [4:0]           rob_head;
  logic [5:0]           rob_count;
  logic                 flush;
  logic [1:0]           head_advance;
  logic [1:0]           ret_valid;
  logic [1:0]           ret_wr_en;
  logic [1:0][4:0]      ret_wr_idx;
  logic [1:0][31:0]     ret_wr_data;
  logic [1:0][31:0]     ret_NPC;
  logic [3:0]           completed_insts;
  EXCEPTION_CODE        error_status;
  logic                 halted;

  retire_stage_nw #(.ROB_SZ(32), .RETIRE_W(2), .CMPL_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmpl_valid(cmpl_valid), .cmpl_rob_idx(cmpl_rob_idx), .cmpl_wr_en(cmpl_wr_en),
    .cmpl_wr_idx(cmpl_wr_idx), .cmpl_wr_data(cmpl_wr_data), .cmpl_NPC(cmpl_NPC),
    .cmpl_error(cmpl_error), .rob_head(rob_head), .rob_count(rob_count), .flush(flush),
    .head_advance(head_advance), .ret_valid(ret_valid), .ret_wr_en(ret_wr_en),
    .ret_wr_idx(ret_wr_idx), .ret_wr_data(ret_wr_data), .ret_NPC(ret_NPC),
    .completed_insts(completed_insts), .error_status(error_status), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    cv;
    logic [4:0]    s0;
    EXCEPTION_CODE e0;
    logic [4:0]    s1;
    EXCEPTION_CODE e1;
    logic [4:0]    head;
    logic [5:0]    cnt;
    logic          fl;
    logic [1:0]    rv;
    logic [1:0]    ha;
    EXCEPTION_CODE err;
    logic          halt;
  } vec_t;

  vec_t vt[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Payload is a fixed function of the slot so retired data can be predicted.
  function automatic logic [4:0]  f_idx(input logic [4:0] s);  return 5'(s + 5'd5); endfunction
  function automatic logic [31:0] f_data(input logic [4:0] s); return 32'hDEAD + 32'h1111 * 32'(s); endfunction
  function automatic logic [31:0] f_npc(input logic [4:0] s);  return 32'h8000_0000 + 32'(s) * 4; endfunction
  function automatic logic        f_en(input logic [4:0] s);   return (s % 3) != 2; endfunction

  function automatic vec_t mk(input logic [1:0] cv, input logic [4:0] s0, input EXCEPTION_CODE e0,
                              input logic [4:0] s1, input EXCEPTION_CODE e1, input logic [4:0] head,
                              input logic [5:0] cnt, input logic fl, input logic [1:0] rv,
                              input logic [1:0] ha, input EXCEPTION_CODE err, input logic halt);
    vec_t v;
    v.cv = cv; v.s0 = s0; v.e0 = e0; v.s1 = s1; v.e1 = e1; v.head = head; v.cnt = cnt;
    v.fl = fl; v.rv = rv; v.ha = ha; v.err = err; v.halt = halt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_out();
    vec_t        e;
    logic [4:0]  s;
    e = exp_q.pop_front();
    chk("ret_valid", 64'(ret_valid), 64'(e.rv));
    chk("head_advance", 64'(head_advance), 64'(e.ha));
    chk("completed_insts", 64'(completed_insts), 64'(e.ha));
    chk("error_status", 64'(error_status), 64'(e.err));
    chk("halted", 64'(halted), 64'(e.halt));
    for (int i = 0; i < 2; i++) begin
      s = 5'(e.head + 5'(i));
      chk($sformatf("wr_en%0d", i),   64'(ret_wr_en[i]),   e.rv[i] ? 64'(f_en(s))   : 64'd0);
      chk($sformatf("wr_idx%0d", i),  64'(ret_wr_idx[i]),  e.rv[i] ? 64'(f_idx(s))  : 64'd0);
      chk($sformatf("wr_data%0d", i), 64'(ret_wr_data[i]), e.rv[i] ? 64'(f_data(s)) : 64'd0);
      chk($sformatf("NPC%0d", i),     64'(ret_NPC[i]),     e.rv[i] ? 64'(f_npc(s))  : 64'd0);
    end
  endtask

  task automatic drive(input vec_t v);
    logic [4:0] sl [2];
    @(negedge clock);
    sl[0] = v.s0;
    sl[1] = v.s1;
    cmpl_valid = v.cv;
    for (int p = 0; p < 2; p++) begin
      cmpl_rob_idx[p] = sl[p];
      cmpl_wr_en[p]   = f_en(sl[p]);
      cmpl_wr_idx[p]  = f_idx(sl[p]);
      cmpl_wr_data[p] = f_data(sl[p]);
      cmpl_NPC[p]     = f_npc(sl[p]);
    end
    cmpl_error[0] = v.e0;
    cmpl_error[1] = v.e1;
    rob_head  = v.head;
    rob_count = v.cnt;
    flush     = v.fl;
    exp_q.push_back(v);
    #2;
    check_out();
  endtask

  localparam EXCEPTION_CODE NO = NO_ERROR;
  localparam EXCEPTION_CODE IL = ILLEGAL_INST;
  localparam EXCEPTION_CODE WF = HALTED_ON_WFI;

  initial begin
    cmpl_valid = '0; cmpl_rob_idx = '0; cmpl_wr_en = '0; cmpl_wr_idx = '0;
    cmpl_wr_data = '0; cmpl_NPC = '0; cmpl_error = '{NO_ERROR, NO_ERROR};
    rob_head = '0; rob_count = '0; flush = 1'b0;

    //        cv    s0  e0  s1  e1  head cnt  fl  rv     ha  err halt
    vt.push_back(mk(2'b01, 0, NO, 0, NO, 0,  1,  0, 2'b00, 0, NO, 0)); // complete slot 0
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 0,  1,  0, 2'b01, 1, NO, 0)); // retires next cycle
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 1,  0,  0, 2'b00, 0, NO, 0));
    vt.push_back(mk(2'b11, 31, NO, 0, NO, 31, 2, 0, 2'b00, 0, NO, 0)); // wrap capture
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 31, 2,  0, 2'b11, 2, NO, 0)); // wrap retire
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 1,  0,  0, 2'b00, 0, NO, 0));
    vt.push_back(mk(2'b01, 1, NO, 0, NO, 0,  3,  0, 2'b00, 0, NO, 0)); // slot 1 only
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 0,  3,  0, 2'b00, 0, NO, 0)); // head blocked
    vt.push_back(mk(2'b01, 0, NO, 0, NO, 0,  3,  0, 2'b00, 0, NO, 0));
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 0,  3,  0, 2'b11, 2, NO, 0));
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 2,  1,  0, 2'b00, 0, NO, 0)); // slot 2 pending
    vt.push_back(mk(2'b01, 2, NO, 0, NO, 2,  0,  0, 2'b00, 0, NO, 0));
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 2,  0,  0, 2'b00, 0, NO, 0)); // stale valid, empty
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 2,  1,  0, 2'b01, 1, NO, 0)); // count limits lane 1
    vt.push_back(mk(2'b11, 4, NO, 5, NO, 4,  3,  0, 2'b00, 0, NO, 0));
    vt.push_back(mk(2'b01, 6, NO, 0, NO, 4,  0,  0, 2'b00, 0, NO, 0));
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 4,  3,  1, 2'b11, 2, NO, 0)); // retire in flush cycle
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 6,  1,  0, 2'b00, 0, NO, 0)); // slot 6 flushed
    vt.push_back(mk(2'b01, 6, NO, 0, NO, 6,  1,  1, 2'b00, 0, NO, 0)); // capture under flush
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 6,  1,  0, 2'b00, 0, NO, 0)); // ... was dropped
    vt.push_back(mk(2'b01, 6, NO, 0, NO, 6,  1,  0, 2'b00, 0, NO, 0));
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 6,  1,  0, 2'b01, 1, NO, 0));
    vt.push_back(mk(2'b11, 7, NO, 8, NO, 7,  32, 0, 2'b00, 0, NO, 0)); // full ROB
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 7,  32, 0, 2'b11, 2, NO, 0));
    vt.push_back(mk(2'b11, 9, IL, 10, NO, 9, 2,  0, 2'b00, 0, NO, 0)); // faulting head
    vt.push_back(mk(2'b00, 0, NO, 0, NO, 9,  2,  0, 2'b01, 1, NO, 0));
    vt.push_back(mk(2'b01, 11, NO, 0, NO, 10, 1, 0, 2'b00, 0, IL, 1)); // halted, capture taken

    #1;
    chk("rst ret_valid", 64'(ret_valid), 64'd0);
    chk("rst head_advance", 64'(head_advance), 64'd0);
    chk("rst completed_insts", 64'(completed_insts), 64'd0);
    chk("rst error_status", 64'(error_status), 64'(NO_ERROR));
    chk("rst halted", 64'(halted), 64'd0);
    #11 reset_n = 1'b1;

    foreach (vt[k]) drive(vt[k]);

    for (int k = 0; k < 10; k++)
      drive(mk(2'b00, 0, NO, 0, NO, 10, 1, 0, 2'b00, 0, IL, 1));

    // Asynchronous reset in the middle of a cycle.
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async halted", 64'(halted), 64'd0);
    chk("async error_status", 64'(error_status), 64'(NO_ERROR));
    chk("async ret_valid", 64'(ret_valid), 64'd0);
    chk("async head_advance", 64'(head_advance), 64'd0);
    #1 reset_n = 1'b1;

    drive(mk(2'b00, 0, NO, 0, NO, 10, 1, 0, 2'b00, 0, NO, 0)); // slot 10 wiped
    drive(mk(2'b01, 0, WF, 0, NO, 0,  1, 0, 2'b00, 0, NO, 0));
    drive(mk(2'b00, 0, NO, 0, NO, 0,  1, 0, 2'b01, 1, NO, 0));
    drive(mk(2'b00, 0, NO, 0, NO, 1,  2, 0, 2'b00, 0, WF, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/retire_stage_nw.md
Name: retire_stage_nw

Overview:
N-wide in-order retire stage with registered per-ROB-entry completion storage.
- Captures completion packets from up to C completion ports into a ROB-indexed buffer.
- Each cycle, retires up to W consecutive completed entries starting at the ROB head; drives commit and architectural-status outputs and tells the ROB how far to advance its head.
- Sits between complete stage and ROB/regfile. Stops retiring permanently after a halt or error instruction retires.

Parameters:
ROB_SZ, 32, ROB entries; power of two, ≥ 4
RETIRE_W, 2, max retires per cycle; 1 ≤ RETIRE_W ≤ ROB_SZ
CMPL_W, 2, completion ports per cycle; ≥ 1
IDX_W, $clog2(ROB_SZ), ROB index width (derived, not overridable)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmpl_valid  in  CMPL_W  completion port valid
- cmpl_rob_idx  in  CMPL_W×IDX_W  ROB slot being completed
- cmpl_wr_en  in  CMPL_W  writes a destination register
- cmpl_wr_idx  in  CMPL_W×5  destination arch register
- cmpl_wr_data  in  CMPL_W×XLEN  result value
- cmpl_NPC  in  CMPL_W×XLEN  next PC of the instruction
- cmpl_error  in  CMPL_W×EXCEPTION_CODE  NO_ERROR, ILLEGAL_INST, HALTED_ON_WFI or LOAD_ACCESS_FAULT
- rob_head  in  IDX_W  current ROB head
- rob_count  in  IDX_W+1  occupied ROB entries, 0..ROB_SZ
- flush  in  1  squash all pending entries
- head_advance  out  $clog2(RETIRE_W+1)  entries retired this cycle
- ret_valid  out  RETIRE_W  lane i retires
- ret_wr_en / ret_wr_idx / ret_wr_data / ret_NPC  out  per lane  commit info
- completed_insts  out  4  popcount of ret_valid
- error_status  out  EXCEPTION_CODE  architectural status
- halted  out  1  retire frozen

Behaviour:
- Reset (reset_n low, asynchronous): all buffer valid bits 0; state RUN; error_status = NO_ERROR; halted = 0. All combinational outputs are 0 while no entry is valid.
- Capture: on a rising edge, each valid completion port writes its slot and sets valid = 1.
  - Data is visible to the retire logic the next cycle. Minimum completion-to-retire latency is 1 cycle.
  - Two ports naming the same slot in one cycle is illegal; assert in simulation. The higher port index wins in RTL.
- Retire candidates (combinational): lane i examines slot (rob_head + i) mod ROB_SZ; index arithmetic truncates to IDX_W.
  - Lane i retires iff all of the following hold:
    - state == RUN;
    - i < rob_count;
    - the slot is valid;
    - lanes 0..i-1 all retire;
    - no lane j < i carries cmpl_error != NO_ERROR.
  - A faulting or halting entry retires in its own lane; younger lanes that cycle do not retire.
- head_advance = number of retiring lanes; ret_* are driven from the stored entry.
- completed_insts = head_advance zero-extended to 4 bits. An erroring instruction counts as completed.
- Clear: on the edge, retired slots have valid cleared.
  - If a completion writes a slot in the same cycle it retires (illegal reuse), the clear wins; assert in simulation.
- State machine:
  - RUN → HALTED when a retiring lane has error != NO_ERROR. error_status latches that code.
  - HALTED is absorbing until reset: head_advance = 0, ret_valid = 0, captures still accepted but never retired.
- error_status otherwise holds NO_ERROR. Other EXCEPTION_CODE values are never produced.
- flush: at the edge, all valid bits clear; same-cycle captures are dropped.
  - Retire outputs in the flush cycle are still valid; the flush is applied after them.
  - flush has no effect on state.
- Wrap: rob_head = ROB_SZ-1 with W = 2 retires slots ROB_SZ-1 and 0.
- Empty (rob_count = 0): nothing retires even if stale valid bits exist.
- Full (rob_count = ROB_SZ): behaves normally.
- Reset mid-operation: immediate asynchronous clear; any in-flight retire is lost.

Decomposition:
- Shared package holds:
  - EXCEPTION_CODE;
  - a new RETIRE_ENTRY typedef: valid, wr_en, wr_idx, wr_data, NPC, error;
  - a RETIRE_STATE enum {RET_RUN, RET_HALTED};
  - XLEN and ROB_SZ defaults.
- One natural sub-module, retire_select: purely combinational lane-eligibility and prefix-AND chain. It takes valid/error of the W head slots plus rob_count and state, and produces ret_valid and head_advance. Storage and the FSM stay in the top.

Test Plan:
- Reset, then complete slot 0 (wr_idx 5, data 0xDEAD) with head = 0 and count = 1 → the following cycle: ret_valid = 01, ret_wr_idx = 5, ret_wr_data = 0xDEAD, head_advance = 1, completed_insts = 1.
- W = 2, head = 31, count = 2; complete slots 31 and 0 on ports 0 and 1 in the same cycle → next cycle: both lanes retire, head_advance = 2.
- Complete slot 1 only (head = 0, count = 3) → no retire. Then complete slot 0 → next cycle: 2 retire. Slot 2 is not complete, so the third entry stays pending.
- Slots 0 and 1 complete; slot 0 carries ILLEGAL_INST → only lane 0 retires, error_status = ILLEGAL_INST, halted = 1. Slot 1 never retires, even after 10 more cycles.
- Slots 4–6 complete with head = 4, then assert flush → no retire occurs in any later cycle until the slots are re-completed. Deassert reset_n mid-run → outputs go to 0 asynchronously and halted clears.
- count = 0 with stale valid slot at head → head_advance = 0. Slot 0 holding HALTED_ON_WFI retires → error_status = HALTED_ON_WFI, completed_insts = 1.
